dm_cache_ctrl: RTL and testbench
================================

// Module: dm_cache_ctrl
// PURPOSE
//   Read-only direct-mapped cache controller between the CPU load port and main memory.
//   - Looks up each CPU word request in a tag/valid/data array.
//   - On a miss, initiates a block fetch: presents the block-aligned address with read
//     enable, then captures the returned 128-bit block into the line.
//   - Returns the requested word with a hit flag, and keeps hit/access statistics.
// PARAMETERS
//   ADDR_W      15  word address width (CPU and memory)
//   WORD_W      32  data word width
//   BLOCK_WORDS 4   words per block; offset width = log2(BLOCK_WORDS) = 2
//   INDEX_W     8   line index width (256 lines); TAG_W = ADDR_W-INDEX_W-2 = 5
//   MEM_LAT     1   cycles from memory address presentation to a valid mem_block_in (>=1)
//   CNT_W       16  statistics counter width
// PORTS
//   clk             in   1                  clock
//   rst             in   1                  reset, asynchronous, active-high
//   cpu_req_valid   in   1                  CPU read request
//   cpu_req_addr    in   ADDR_W             CPU word address
//   cpu_req_ready   out  1                  controller accepts a request this cycle
//   cpu_rsp_valid   out  1                  one-cycle response strobe
//   cpu_rsp_data    out  WORD_W             requested word
//   cpu_rsp_hit     out  1                  1 = served from cache, 0 = refilled
//   mem_read_enable out  1                  block fetch active
//   mem_address     out  ADDR_W             {tag,index,2'b00} of the line being fetched
//   mem_block_in    in   WORD_W*BLOCK_WORDS word i of block in bits [32i+31:32i]
//   hit_count       out  CNT_W              saturating hit counter
//   access_count    out  CNT_W              saturating accepted-request counter
// BEHAVIOUR
//   - Address split: offset=[1:0], index=[INDEX_W+1:2], tag=[ADDR_W-1:INDEX_W+2].
//   - Reset (async): state=IDLE; all valid bits, counters and every output = 0, except
//     cpu_req_ready = 1. Tag and data arrays are not reset.
//   - Handshake: request accepted when cpu_req_valid && cpu_req_ready. cpu_req_ready is
//     high only in IDLE. The address is registered on acceptance and the CPU may change it.
//   - FSM states and transitions:
//     - IDLE   -> LOOKUP on accept; access_count++.
//     - LOOKUP: hit = valid[idx] && tag match.
//       - Hit: latch word, cpu_rsp_hit=1, hit_count++, -> RESPOND.
//       - Miss: -> FETCH.
//     - FETCH: mem_read_enable=1 and mem_address stable for exactly MEM_LAT cycles. At the
//       end of the last cycle, write the block to data[idx], tag[idx] and valid[idx]=1,
//       latch the requested word, set cpu_rsp_hit=0, -> RESPOND.
//     - RESPOND: cpu_rsp_valid=1 for one cycle with data/hit stable, -> IDLE.
//   - Latency (accept edge = cycle N): hit response in N+2; miss response in N+2+MEM_LAT.
//     The next accept is possible one cycle after RESPOND.
//   - mem_read_enable and mem_address are 0 outside FETCH.
//   - cpu_rsp_data/hit hold their last values after RESPOND.
//   - Counters saturate at all-ones and never wrap.
//   - Reset mid-FETCH: abort; no line is written; mem_read_enable drops immediately
//     (async); no response is issued.
//   - A miss to a valid line of a different tag overwrites it; no writeback (read-only).
//   - Highest block (addr 0x7FFC-0x7FFF) is handled like any other block.
// STRUCTURE
//   - Package dm_cache_pkg:
//     - state enum {IDLE, LOOKUP, FETCH, RESPOND}
//     - localparams OFFSET_W, TAG_W, LINES, BLOCK_W
//     - functions get_tag/get_index/get_offset
//   - Sub-module dm_cache_array: tag/data storage with async-reset valid vector,
//     combinational read port and one synchronous line-fill write port.
//   - The FSM, counters and MEM_LAT wait counter stay in dm_cache_ctrl.
// TESTING (MEM_LAT=1; memory model returns block {D3,D2,D1,D0} for base 0x0404)
//   1. Cold miss: after reset, req 0x0405 -> mem_read_enable=1, mem_address=0x0404 for
//      1 cycle; rsp at N+3 with data=D1, hit=0; access_count=1, hit_count=0.
//   2. Hit: req 0x0406 -> no mem_read_enable; rsp at N+2 with data=D2, hit=1; hit_count=1.
//   3. Conflict: req 0x1404 (same index 1, tag 5) -> miss, fetch 0x1404; then req 0x0405
//      -> miss again with mem_address=0x0404; hit_count unchanged.
//   4. Busy: hold cpu_req_valid=1 through LOOKUP/FETCH/RESPOND -> cpu_req_ready=0; exactly
//      one accept per response; access_count increments once per accept.
//   5. Reset mid-FETCH: assert rst during FETCH -> mem_read_enable=0 at once, no rsp; after
//      release, req 0x0405 misses (valid cleared), counters restart at 0.
//   6. Saturation: preload counters near 16'hFFFF (force), issue 3 hits -> both hold FFFF.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared types, geometry and address helpers for the direct-mapped read cache.
package dm_cache_pkg;

  localparam int ADDR_W      = 15;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int INDEX_W     = 8;
  localparam int CNT_W       = 16;

  localparam int OFFSET_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int BLOCK_W  = WORD_W * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FETCH   = 2'd2,
    RESPOND = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Picks word 'off' out of a block; word i lives in bits [WORD_W*i +: WORD_W].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (off == OFFSET_W'(i)) begin
        w = blk[WORD_W*i +: WORD_W];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/data storage: valid bits are reset, tags and data are not.
// One combinational read port, one synchronous whole-line fill port.
module dm_cache_array
  import dm_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_block,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_block
);

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];

  // Valid vector: cleared asynchronously, set when a line is filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data storage written on a line fill; contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_block;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: lookup, block refill from memory,
// one-cycle response strobe, saturating hit/access statistics.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cpu_req_valid,
  input  logic [ADDR_W-1:0]  i_cpu_req_addr,
  output logic               o_cpu_req_ready,
  output logic               o_cpu_rsp_valid,
  output logic [WORD_W-1:0]  o_cpu_rsp_data,
  output logic               o_cpu_rsp_hit,
  output logic               o_mem_read_enable,
  output logic [ADDR_W-1:0]  o_mem_address,
  input  logic [BLOCK_W-1:0] i_mem_block_in,
  output logic [CNT_W-1:0]   o_hit_count,
  output logic [CNT_W-1:0]   o_access_count
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LAT_W-1:0]   r_wait;
  logic               r_cpu_req_ready;
  logic               r_cpu_rsp_valid;
  logic [WORD_W-1:0]  r_cpu_rsp_data;
  logic               r_cpu_rsp_hit;
  logic               r_mem_read_enable;
  logic [ADDR_W-1:0]  r_mem_address;
  logic [CNT_W-1:0]   r_hit_count;
  logic [CNT_W-1:0]   r_access_count;

  logic               w_accept;
  logic               w_hit;
  logic               w_fill;
  logic               w_rd_valid;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [BLOCK_W-1:0] w_rd_block;

  assign w_accept = i_cpu_req_valid && r_cpu_req_ready;
  assign w_hit    = w_rd_valid && (w_rd_tag == get_tag(r_addr));
  // The fill happens on the closing edge of the last memory wait cycle.
  assign w_fill   = (r_state == FETCH) && (r_wait == LAT_LAST);

  dm_cache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (get_index(r_addr)),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_block (w_rd_block),
    .i_wr_en    (w_fill),
    .i_wr_index (get_index(r_addr)),
    .i_wr_tag   (get_tag(r_addr)),
    .i_wr_block (i_mem_block_in)
  );

  // Controller FSM with registered handshake, memory and response outputs plus statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_addr            <= '0;
      r_wait            <= '0;
      r_cpu_req_ready   <= 1'b1;
      r_cpu_rsp_valid   <= 1'b0;
      r_cpu_rsp_data    <= '0;
      r_cpu_rsp_hit     <= 1'b0;
      r_mem_read_enable <= 1'b0;
      r_mem_address     <= '0;
      r_hit_count       <= '0;
      r_access_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr          <= i_cpu_req_addr;
            r_access_count  <= sat_inc(r_access_count);
            r_cpu_req_ready <= 1'b0;
            r_state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_cpu_rsp_data  <= select_word(w_rd_block, get_offset(r_addr));
            r_cpu_rsp_hit   <= 1'b1;
            r_cpu_rsp_valid <= 1'b1;
            r_hit_count     <= sat_inc(r_hit_count);
            r_state         <= RESPOND;
          end else begin
            r_mem_read_enable <= 1'b1;
            r_mem_address     <= {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_wait            <= '0;
            r_state           <= FETCH;
          end
        end
        FETCH: begin
          if (w_fill) begin
            r_mem_read_enable <= 1'b0;
            r_mem_address     <= '0;
            r_cpu_rsp_data    <= select_word(i_mem_block_in, get_offset(r_addr));
            r_cpu_rsp_hit     <= 1'b0;
            r_cpu_rsp_valid   <= 1'b1;
            r_state           <= RESPOND;
          end else begin
            r_wait <= r_wait + LAT_W'(1);
          end
        end
        RESPOND: begin
          r_cpu_rsp_valid <= 1'b0;
          r_cpu_req_ready <= 1'b1;
          r_state         <= IDLE;
        end
        default: begin
          r_cpu_rsp_valid   <= 1'b0;
          r_mem_read_enable <= 1'b0;
          r_mem_address     <= '0;
          r_cpu_req_ready   <= 1'b1;
          r_state           <= IDLE;
        end
      endcase
    end
  end

  assign o_cpu_req_ready   = r_cpu_req_ready;
  assign o_cpu_rsp_valid   = r_cpu_rsp_valid;
  assign o_cpu_rsp_data    = r_cpu_rsp_data;
  assign o_cpu_rsp_hit     = r_cpu_rsp_hit;
  assign o_mem_read_enable = r_mem_read_enable;
  assign o_mem_address     = r_mem_address;
  assign o_hit_count       = r_hit_count;
  assign o_access_count    = r_access_count;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed table, hand-written corner
// sequences and randomized requests against a line-level cache model.
module tb_dm_cache_ctrl;
  import dm_cache_pkg::*;

  localparam int MEM_LAT = 1;

  logic               clk;
  logic               rst;
  logic               cpu_req_valid;
  logic [ADDR_W-1:0]  cpu_req_addr;
  logic               cpu_req_ready;
  logic               cpu_rsp_valid;
  logic [WORD_W-1:0]  cpu_rsp_data;
  logic               cpu_rsp_hit;
  logic               mem_read_enable;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_block_in;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   access_count;

  dm_cache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_cpu_req_valid   (cpu_req_valid),
    .i_cpu_req_addr    (cpu_req_addr),
    .o_cpu_req_ready   (cpu_req_ready),
    .o_cpu_rsp_valid   (cpu_rsp_valid),
    .o_cpu_rsp_data    (cpu_rsp_data),
    .o_cpu_rsp_hit     (cpu_rsp_hit),
    .o_mem_read_enable (mem_read_enable),
    .o_mem_address     (mem_address),
    .i_mem_block_in    (mem_block_in),
    .o_hit_count       (hit_count),
    .o_access_count    (access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory contents: every word is a fixed scramble of its own address.
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return ({17'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory model: returns the block at the presented address.
  always_comb begin
    mem_block_in = '0;
    for (int i = 0; i < 4; i++) begin
      mem_block_in[32*i +: 32] = mem_word(mem_address + 15'(i));
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: one valid/tag per line, plus saturating counters.
  bit         m_valid [256];
  logic [4:0] m_tag   [256];
  int         m_hits;
  int         m_acc;

  function automatic int sat16(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  function automatic bit model_hit(input logic [14:0] a);
    return m_valid[a[9:2]] && (m_tag[a[9:2]] == a[14:10]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_acc  = 0;
  endtask

  // One full transaction: accept, track memory activity, check response and counters.
  task automatic run_req(input logic [14:0] a, input bit exp_hit, input string nm);
    int cyc;
    int rd_cnt;
    bit got;
    bit addr_bad;
    logic [31:0] rsp_d;
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    @(negedge clk);
    chk({nm, " ready"}, 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 15'($urandom);
    m_acc = sat16(m_acc);
    if (exp_hit) m_hits = sat16(m_hits);
    m_valid[a[9:2]] = 1'b1;
    m_tag[a[9:2]]   = a[14:10];
    cyc = 0; rd_cnt = 0; got = 1'b0; addr_bad = 1'b0;
    while (!got && cyc < 12) begin
      cyc++;
      if (mem_read_enable) begin
        rd_cnt++;
        if (mem_address !== base) addr_bad = 1'b1;
      end
      if (cpu_rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " rsp_seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(cyc), exp_hit ? 32'd2 : 32'(2 + MEM_LAT));
    chk({nm, " data"}, cpu_rsp_data, mem_word(a));
    chk({nm, " hit"}, 32'(cpu_rsp_hit), 32'(exp_hit));
    chk({nm, " fetch_cycles"}, 32'(rd_cnt), exp_hit ? 32'd0 : 32'(MEM_LAT));
    chk({nm, " fetch_addr_bad"}, 32'(addr_bad), 32'd0);
    chk({nm, " access_count"}, 32'(access_count), 32'(m_acc));
    chk({nm, " hit_count"}, 32'(hit_count), 32'(m_hits));
    rsp_d = cpu_rsp_data;
    @(negedge clk);
    chk({nm, " rsp_one_cycle"}, 32'(cpu_rsp_valid), 32'd0);
    chk({nm, " data_hold"}, cpu_rsp_data, rsp_d);
    chk({nm, " ready_back"}, 32'(cpu_req_ready), 32'd1);
    chk({nm, " idle_mem"}, {16'(mem_read_enable), 1'b0, mem_address}, 32'd0);
  endtask

  typedef struct {
    logic [14:0] addr;
    bit          exp_hit;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int acc;
    int rsp;
    int overlap;
    int base_acc;
    int base_hits;
    bit seen;
    logic [14:0] ra;

    tbl[0] = '{15'h0405, 1'b0};  // cold miss
    tbl[1] = '{15'h0406, 1'b1};  // hit in same block
    tbl[2] = '{15'h1404, 1'b0};  // conflict, same index, tag 5
    tbl[3] = '{15'h0405, 1'b0};  // evicted, misses again
    tbl[4] = '{15'h0407, 1'b1};
    tbl[5] = '{15'h0404, 1'b1};
    tbl[6] = '{15'h7FFF, 1'b0};  // highest block
    tbl[7] = '{15'h7FFC, 1'b1};
    tbl[8] = '{15'h0000, 1'b0};
    tbl[9] = '{15'h0003, 1'b1};

    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(cpu_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("reset rsp_data", cpu_rsp_data, 32'd0);
    chk("reset rsp_hit", 32'(cpu_rsp_hit), 32'd0);
    chk("reset mem", {16'(mem_read_enable), 1'b0, mem_address}, 32'd0);
    chk("reset counters", {hit_count, access_count}, 32'd0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_req(tbl[i].addr, tbl[i].exp_hit, $sformatf("tbl%0d", i));
    end

    // Randomized traffic over a small footprint to mix hits, misses and conflicts.
    for (int i = 0; i < 60; i++) begin
      ra = {5'($urandom_range(0, 2)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) ra[9:2] = 8'hFF;
      run_req(ra, model_hit(ra), $sformatf("rnd%0d", i));
    end

    // Busy: hold a request through the whole transaction; one accept per response.
    run_req(15'h0406, model_hit(15'h0406), "busy_prime");
    base_acc  = m_acc;
    base_hits = m_hits;
    acc = 0; rsp = 0; overlap = 0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 15'h0406;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (cpu_rsp_valid) rsp++;
      if (cpu_rsp_valid && cpu_req_ready) overlap++;
      if (i == 29) cpu_req_valid = 1'b0;
      else if (cpu_req_ready) acc++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_rsp_valid) rsp++;
    end
    m_acc  = base_acc + acc;
    m_hits = base_hits + acc;
    chk("busy accepts", 32'(acc), 32'd10);
    chk("busy responses", 32'(rsp), 32'(acc));
    chk("busy ready_during_rsp", 32'(overlap), 32'd0);
    chk("busy access_count", 32'(access_count), 32'(m_acc));
    chk("busy hit_count", 32'(hit_count), 32'(m_hits));

    // Reset in the middle of a fetch.
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 15'h7D54;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (mem_read_enable) seen = 1'b1;
    end
    chk("rstfetch fetch_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstfetch rd_en_drop", 32'(mem_read_enable), 32'd0);
    chk("rstfetch mem_addr", 32'(mem_address), 32'd0);
    chk("rstfetch no_rsp", 32'(cpu_rsp_valid), 32'd0);
    chk("rstfetch counters", {hit_count, access_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_rsp_valid) rsp++;
    end
    chk("rstfetch quiet", 32'(rsp), 32'd0);
    run_req(15'h0405, 1'b0, "post_rst_0405");
    run_req(15'h7D54, 1'b0, "post_rst_7d54");
    run_req(15'h0406, 1'b1, "post_rst_0406");

    // Saturation: preload both counters just below all-ones, then three hits.
    @(negedge clk);
    force dut.r_hit_count    = 16'hFFFE;
    force dut.r_access_count = 16'hFFFD;
    #1;
    release dut.r_hit_count;
    release dut.r_access_count;
    m_hits = 32'hFFFE;
    m_acc  = 32'hFFFD;
    for (int i = 0; i < 3; i++) begin
      run_req(15'h0404 + 15'(i), 1'b1, $sformatf("sat%0d", i));
    end
    chk("sat hit_final", 32'(hit_count), 32'hFFFF);
    chk("sat access_final", 32'(access_count), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
